vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Downstream consumer of the block-average downscaler's output RAM.
- Generates 640x480@60 Hz VGA timing and reads the downscaled 8-bit grayscale frame (80x60 or 40x30) through the RAM read port.
- Upscales the frame by nearest-neighbour pixel replication to fill the screen and drives grayscale RGB, sync and data-enable to the video DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  pixel clock (25 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- sw  in  1  scale select: 0 = 80x60 image, zoom x8; 1 = 40x30 image, zoom x16
- img_done  in  1  downscaler done flag; RAM content valid when high
- ram_data  in  8  RAM read data, valid 1 clk after ram_addr
- pattern_sel  in  1  test-pattern select (see Optional Feature)
- ram_addr  out  19  RAM read address
- vga_r, vga_g, vga_b  out  8 each  grayscale pixel, all three equal
- hsync  out  1  active-low
- vsync  out  1  active-low
- de  out  1  active-high data enable
- frame_start  out  1  one-clk pulse at the first visible pixel of each frame

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - h_cnt = 0, v_cnt = 0, ram_addr = 0, rgb = 0.
  - hsync = 1, vsync = 1, de = 0, frame_start = 0.
  - Latched scale = 0.
- Counters:
  - h_cnt runs 0..799, wrapping to 0.
  - v_cnt increments when h_cnt wraps, and runs 0..524, wrapping to 0.
- Stage 0 timing (combinational from the counters):
  - Visible when h_cnt < 640 and v_cnt < 480.
  - hsync low for h_cnt 656..751.
  - vsync low for v_cnt 490..491.
- Scale latch: sw is sampled only when h_cnt = 799 and v_cnt = 524 (end of frame). Changing sw mid-frame has no effect until the next frame, so there is no tearing.
- Address generation (stage 0 -> registered ram_addr):
  - Shift s = 3 (scale 0) or 4 (scale 1).
  - Image width W = 80 or 40.
  - ix = h_cnt >> s, iy = v_cnt >> s.
  - ram_addr <= iy*W + ix, computed with shift-add only (80 = 64+16, 40 = 32+8). No divider and no general multiplier.
  - Maximum address is 4799 (80x60) or 1199 (40x30).
  - Outside the visible area, ram_addr holds its last value.
- Pipeline, total latency 2 clks from counter state to pins:
  - Stage 1: RAM returns ram_data.
  - Stage 2: rgb, de, hsync, vsync and frame_start are registered together.
  - Sync and de are delayed 2 stages so they stay aligned with the pixel data.
- Pixel value:
  - When de is high: rgb = ram_data if img_done = 1, else 0 (black). img_done is sampled in stage 1.
  - When de is low: rgb = 0.
- frame_start: high for exactly 1 clk, coincident with de's first rising edge of the frame (pixel 0,0).
- img_done dropping mid-frame: output turns black from the next pixel onward. Timing is unaffected.
- Reset mid-frame: all outputs return to reset values immediately. Timing restarts at h_cnt = 0, v_cnt = 0 after release.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: when pattern_sel = 1, visible pixels show h_cnt[7:0] XOR v_cnt[7:0], regardless of img_done and ram_data.
  - The pattern uses the same 2-clk alignment as RAM pixels.
  - ram_addr keeps updating normally.
- Undefined: pattern_sel is ignored and there is no extra logic.

Test Plan:
- Timing: release reset, run 2 frames -> hsync period 800 clks with a 96-clk low pulse; vsync period 420000 clks with a low pulse of 2 lines (1600 clks); de high for 640 clks per line on 480 lines.
- Addressing, sw = 0, RAM model returns addr[7:0]: pixel (h=8, v=0) -> ram_addr = 1; pixel (h=0, v=8) -> ram_addr = 80; last visible pixel -> ram_addr = 4799; each value is held for 8 pixels and 8 lines.
- Addressing, sw = 1: pixel (h=16, v=16) -> ram_addr = 41; last visible pixel -> ram_addr = 1199. Toggle sw at mid-frame -> the change takes effect only from the next frame_start.
- Latency: RAM returns 0xA5 at address 0, img_done = 1 -> rgb = 0xA5 on the same clk de first rises; frame_start pulses once on that clk.
- img_done = 0 -> all visible pixels are 0, while ram_addr still sequences normally.
- With VGA_TEST_PATTERN_EN and pattern_sel = 1: pixel (h=5, v=3) -> rgb = 0x06; reset asserted mid-line -> hsync = 1, vsync = 1, de = 0, rgb = 0 immediately.

Source files
------------

// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Generates 640x480@60 VGA timing and reads the downscaled grayscale frame
//   (80x60 or 40x30) from the downscaler's output RAM. The frame is upscaled
//   to full screen by nearest-neighbour replication (x8 or x16).
//
//   Optional build macro: VGA_TEST_PATTERN_EN
//     defined   -> pattern_sel = 1 shows h_cnt[7:0] ^ v_cnt[7:0] on visible pixels
//     undefined -> pattern_sel is ignored and no pattern logic is built
//
// Ports
//   clk          pixel clock (25 MHz nominal)
//   rst          asynchronous, active-high reset
//   sw           scale select, latched once per frame (0: 80x60 x8, 1: 40x30 x16)
//   img_done     RAM content valid flag; pixels are black while low
//   ram_data     RAM read data, valid 1 clk after ram_addr
//   pattern_sel  test pattern select (macro-dependent)
//   ram_addr     RAM read address (registered)
//   vga_r/g/b    grayscale pixel, all three equal
//   hsync/vsync  active-low syncs
//   de           active-high data enable
//   frame_start  1-clk pulse with pixel (0,0)
//
// Pipeline: stage 0 = counters (comb decode), stage 1 = ram_addr register /
// RAM returns data, stage 2 = output registers. Sync and de travel through
// the same two stages so they stay aligned with the pixel data.
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw,
  input  logic        img_done,
  input  logic [7:0]  ram_data,
  input  logic        pattern_sel,
  output logic [18:0] ram_addr,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);

  localparam int STAGES = 2;

  // 10-bit counters cover totals up to 1024 (800 x 525 for the default mode).
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_B  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_B  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_MAX = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // Side-band timing that rides along with the pixel.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic fs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

  logic [9:0]        h_cnt, v_cnt;
  logic              scale;
  logic              vis0;
  sync_t             sync0;
  logic [18:0]       addr0;
  logic [STAGES-1:0] vld_pipe;
  sync_t [STAGES-1:0] sync_pipe;
  logic              done1;
  logic [7:0]        pix1;
  logic [7:0]        rgb;

  // ---------------- counters + per-frame scale latch ----------------
  // sw is only sampled at the very last clock of the frame so a mid-frame
  // change never tears the picture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      scale <= 1'b0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      if (v_cnt == V_MAX) begin
        v_cnt <= '0;
        scale <= sw;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // ---------------- stage 0: decode ----------------
  always_comb begin
    vis0       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    sync0.hs_n = !((h_cnt >= HS_B) && (h_cnt < HS_E));
    sync0.vs_n = !((v_cnt >= VS_B) && (v_cnt < VS_E));
    sync0.fs   = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  // Image address = iy*W + ix with W = 80 (64+16) or 40 (32+8), shift-add only.
  logic [18:0] ix, iy;
  always_comb begin
    ix = scale ? 19'(h_cnt >> 4) : 19'(h_cnt >> 3);
    iy = scale ? 19'(v_cnt >> 4) : 19'(v_cnt >> 3);
    addr0 = scale ? ((iy << 5) + (iy << 3) + ix)
                  : ((iy << 6) + (iy << 4) + ix);
  end

  // ---------------- stage 1: address out, RAM answers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr     <= '0;
      done1        <= 1'b0;
      vld_pipe[0]  <= 1'b0;
      sync_pipe[0] <= SYNC_IDLE;
    end else begin
      if (vis0) ram_addr <= addr0;   // holds through blanking
      done1        <= img_done;
      vld_pipe[0]  <= vis0;
      sync_pipe[0] <= sync0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [7:0] pat1;
  logic       psel1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat1  <= '0;
      psel1 <= 1'b0;
    end else begin
      pat1  <= h_cnt[7:0] ^ v_cnt[7:0];
      psel1 <= pattern_sel;
    end
  end

  assign pix1 = psel1 ? pat1 : (done1 ? ram_data : 8'd0);
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pix1 = done1 ? ram_data : 8'd0;
`endif

  // ---------------- stage 2: output registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb          <= '0;
      vld_pipe[1]  <= 1'b0;
      sync_pipe[1] <= SYNC_IDLE;
    end else begin
      rgb          <= vld_pipe[0] ? pix1 : 8'd0;
      vld_pipe[1]  <= vld_pipe[0];
      sync_pipe[1] <= sync_pipe[0];
    end
  end

  assign vga_r       = rgb;
  assign vga_g       = rgb;
  assign vga_b       = rgb;
  assign de          = vld_pipe[STAGES-1];
  assign hsync       = sync_pipe[STAGES-1].hs_n;
  assign vsync       = sync_pipe[STAGES-1].vs_n;
  assign frame_start = sync_pipe[STAGES-1].fs;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader
//   Directed bench for vga_frame_reader. Horizontal timing is the real
//   800-clock line; vertical timing is shortened to 20 visible lines + 1 FP +
//   2 sync + 1 BP = 24 lines, so one frame is 19200 clocks.
//   Pixel (h,v) of frame f is decoded at cycle f*19200 + v*800 + h, appears
//   on ram_addr one cycle later and on the output pins two cycles later.
module tb_vga_frame_reader;

  localparam int FRAME = 19200;

  logic        clk, rst;
  logic        sw, img_done, pattern_sel;
  logic [7:0]  ram_data;
  logic [18:0] ram_addr;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, de, frame_start;

  vga_frame_reader #(
    .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .img_done(img_done), .ram_data(ram_data),
    .pattern_sel(pattern_sel), .ram_addr(ram_addr),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  // RAM: combinational answer to the registered address; addr 0 holds 0xA5.
  assign ram_data = (ram_addr == 19'd0) ? 8'hA5 : ram_addr[7:0];

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int cyc;
  always_ff @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // ---------------- timing monitor ----------------
  logic mon_en = 1'b0;
  int hs_pmin = 1 << 30, hs_pmax = 0, hs_lmin = 1 << 30, hs_lmax = 0;
  int vs_pmin = 1 << 30, vs_pmax = 0, vs_lmin = 1 << 30, vs_lmax = 0;
  int de_rmin = 1 << 30, de_rmax = 0, ln_min = 1 << 30, ln_max = 0;
  int fs_n = 0, fs_bad = 0;

  initial begin
    logic hs_q, vs_q, de_q, fs_seen;
    int hs_fall, vs_fall, hs_lo, vs_lo, de_run, ln;
    hs_q = 1'b1; vs_q = 1'b1; de_q = 1'b0; fs_seen = 1'b0;
    hs_fall = -1; vs_fall = -1; hs_lo = 0; vs_lo = 0; de_run = 0; ln = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (hs_q && !hsync) begin
          if (hs_fall >= 0) begin
            if (cyc - hs_fall < hs_pmin) hs_pmin = cyc - hs_fall;
            if (cyc - hs_fall > hs_pmax) hs_pmax = cyc - hs_fall;
          end
          hs_fall = cyc; hs_lo = 0;
        end
        if (!hsync) hs_lo++;
        if (!hs_q && hsync) begin
          if (hs_lo < hs_lmin) hs_lmin = hs_lo;
          if (hs_lo > hs_lmax) hs_lmax = hs_lo;
        end
        if (vs_q && !vsync) begin
          if (vs_fall >= 0) begin
            if (cyc - vs_fall < vs_pmin) vs_pmin = cyc - vs_fall;
            if (cyc - vs_fall > vs_pmax) vs_pmax = cyc - vs_fall;
          end
          vs_fall = cyc; vs_lo = 0;
        end
        if (!vsync) vs_lo++;
        if (!vs_q && vsync) begin
          if (vs_lo < vs_lmin) vs_lmin = vs_lo;
          if (vs_lo > vs_lmax) vs_lmax = vs_lo;
        end
        if (frame_start && !(de && !de_q)) fs_bad++;
        if (de && !de_q) begin
          if (frame_start) begin
            if (fs_seen) begin
              if (ln < ln_min) ln_min = ln;
              if (ln > ln_max) ln_max = ln;
            end
            fs_seen = 1'b1; ln = 1; fs_n++;
          end else begin
            ln++;
          end
          de_run = 0;
        end
        if (de) de_run++;
        if (!de && de_q) begin
          if (de_run < de_rmin) de_rmin = de_run;
          if (de_run > de_rmax) de_rmax = de_run;
        end
        hs_q = hsync; vs_q = vsync; de_q = de;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; sw = 1'b0; img_done = 1'b1; pattern_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_addr", ram_addr, 0);
    rst = 1'b0; mon_en = 1'b1;

    // frame 0, scale 0
    goto(1);     chk("f0_de_pre", de, 0);
    goto(2);     chk("f0_de_first", de, 1);
                 chk("f0_fs", frame_start, 1);
                 chk("f0_r_a5", vga_r, 8'hA5);
                 chk("f0_gb_a5", {vga_g, vga_b}, 16'hA5A5);
    goto(3);     chk("f0_fs_once", frame_start, 0);
                 chk("f0_pix1_a5", vga_r, 8'hA5);
    goto(9);     chk("addr_8_0", ram_addr, 1);
    goto(10);    chk("rgb_8_0", vga_r, 8'h01);
    goto(16);    chk("addr_15_0", ram_addr, 1);
    goto(17);    chk("addr_16_0", ram_addr, 2);
    goto(5609);  chk("addr_8_7", ram_addr, 1);
    goto(6401);  chk("addr_0_8", ram_addr, 80);
    goto(6402);  chk("rgb_0_8", vga_r, 8'h50);
    goto(8000);  sw = 1'b1;                        // must not act until frame 1
    goto(12801); chk("addr_0_16_s0", ram_addr, 160);
    goto(15840); chk("addr_last_s0", ram_addr, 239);
    goto(19199); chk("addr_hold", ram_addr, 239);

    // frame 1, scale 1
    goto(FRAME + 1);  chk("f1_addr0", ram_addr, 0);
    goto(FRAME + 2);  chk("f1_fs", frame_start, 1);
                      chk("f1_rgb", vga_r, 8'hA5);
    goto(25000);      sw = 1'b0;                   // takes effect in frame 2
    goto(31841);      chk("rgb_639_15_s1", vga_r, 8'h27);
    goto(32000);      img_done = 1'b0;             // black from pixel (0,16)
    goto(32002);      chk("black_de", de, 1);
                      chk("black_rgb", vga_r, 0);
    goto(32017);      chk("addr_16_16_s1", ram_addr, 41);
    goto(32018);      chk("black_rgb2", vga_r, 0);
    goto(35040);      chk("addr_last_s1", ram_addr, 79);

    // frame 2, scale 0, img_done low
    goto(2*FRAME + 2); chk("f2_fs", frame_start, 1);
                       chk("f2_rgb_black", vga_r, 0);
    goto(44809);       chk("addr_8_8_f2", ram_addr, 81);
    goto(44810);       chk("rgb_8_8_f2", vga_r, 0);
    goto(50000);       pattern_sel = 1'b1;

    // frame 3: pattern (if built), then reset mid-line
`ifdef VGA_TEST_PATTERN_EN
    goto(60007);  chk("pat_5_3", vga_r, 8'h06);
    goto(64017);  chk("pat_addr_16_8", ram_addr, 82);
    goto(64018);  chk("pat_16_8", vga_r, 8'h18);
`else
    goto(60007);  chk("nopat_5_3", vga_r, 0);
    goto(64017);  chk("nopat_addr_16_8", ram_addr, 82);
    goto(64018);  chk("nopat_16_8", vga_r, 0);
`endif
    goto(64700);  chk("pre_rst_hsync", hsync, 0);
    mon_en = 1'b0;

    chk("hs_per_min", hs_pmin, 800);
    chk("hs_per_max", hs_pmax, 800);
    chk("hs_low_min", hs_lmin, 96);
    chk("hs_low_max", hs_lmax, 96);
    chk("vs_per_min", vs_pmin, FRAME);
    chk("vs_per_max", vs_pmax, FRAME);
    chk("vs_low_min", vs_lmin, 1600);
    chk("vs_low_max", vs_lmax, 1600);
    chk("de_run_min", de_rmin, 640);
    chk("de_run_max", de_rmax, 640);
    chk("de_lines_min", ln_min, 20);
    chk("de_lines_max", ln_max, 20);
    chk("fs_count", fs_n, 4);
    chk("fs_not_on_de_rise", fs_bad, 0);

    rst = 1'b1;
    #1;
    chk("mid_rst_hsync", hsync, 1);
    chk("mid_rst_vsync", vsync, 1);
    chk("mid_rst_de", de, 0);
    chk("mid_rst_rgb", vga_r, 0);
    chk("mid_rst_addr", ram_addr, 0);
    sw = 1'b1; img_done = 1'b1; pattern_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    goto(2);   chk("post_rst_fs", frame_start, 1);
               chk("post_rst_rgb", vga_r, 8'hA5);
    goto(9);   chk("post_rst_scale0", ram_addr, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
